// File: rtl/spi_cmd_master_if.sv
// Host-side command/response handshake for spi_cmd_master.
// master: host drives cmd_*; slave: the SPI master returns cmd_ready and rsp_*.
interface spi_cmd_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;

    modport master (
        output cmd_valid, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_cmd_master.sv
// SPI mode-0 master: one command frame, then one read frame for the response.
// Ports: clk, nrst (async low), host (cmd/rsp handshake), busy, spi_ck/mosi/miso/nss.
module spi_cmd_master #(
    parameter int HALF_PERIOD = 8,
    parameter int NSS_LEAD    = 8,
    parameter int NSS_GAP     = 8
) (
    input  logic            clk,
    input  logic            nrst,
    spi_cmd_master_if.slave host,
    output logic            busy,
    output logic            spi_ck,
    output logic            spi_mosi,
    input  logic            spi_miso,
    output logic            spi_nss
);
    localparam int MAXA = (HALF_PERIOD > NSS_LEAD) ? HALF_PERIOD : NSS_LEAD;
    localparam int MAXP = (MAXA > NSS_GAP) ? MAXA : NSS_GAP;
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] HP_END   = CW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] LEAD_END = CW'(NSS_LEAD - 1);
    localparam logic [CW-1:0] GAP_END  = CW'(NSS_GAP - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] LOW   = 3'd2;
    localparam logic [2:0] HIGH  = 3'd3;
    localparam logic [2:0] TRAIL = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_cnt;
    logic          frame;
    logic [7:0]    sh;
    logic [1:0]    miso_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_data_q;
    logic          rsp_err_q;

    assign host.cmd_ready = (state == IDLE);
    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_data  = rsp_data_q;
    assign host.rsp_err   = rsp_err_q;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            miso_q <= 2'b00;
        end else begin
            miso_q <= {miso_q[0], spi_miso};
        end
    end

    // One shift register serves both directions: MOSI leaves from bit 7
    // while synced MISO enters at bit 0, so after 8 bits it holds rx.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= 3'd0;
            frame       <= 1'b0;
            sh          <= 8'h00;
            busy        <= 1'b0;
            spi_ck      <= 1'b0;
            spi_mosi    <= 1'b0;
            spi_nss     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (host.cmd_valid) begin
                        busy     <= 1'b1;
                        frame    <= 1'b0;
                        sh       <= host.cmd_data;
                        spi_nss  <= 1'b0;
                        spi_mosi <= host.cmd_data[7];
                        cnt      <= '0;
                        bit_cnt  <= 3'd0;
                        state    <= LEAD;
                    end
                end
                LEAD: begin
                    if (cnt == LEAD_END) begin
                        cnt    <= '0;
                        spi_ck <= 1'b1;
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (cnt == HP_END) begin
                        cnt     <= '0;
                        spi_ck  <= 1'b0;
                        sh      <= {sh[6:0], miso_q[1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= TRAIL;
                        end else begin
                            spi_mosi <= sh[6];
                            state    <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LOW: begin
                    if (cnt == HP_END) begin
                        cnt    <= '0;
                        spi_ck <= 1'b1;
                        state  <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                TRAIL: begin
                    if (cnt == LEAD_END) begin
                        cnt     <= '0;
                        spi_nss <= 1'b1;
                        state   <= GAP;
                        if (frame) begin
                            rsp_valid_q <= 1'b1;
                            rsp_data_q  <= sh;
                            rsp_err_q   <= ~sh[7];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (cnt == GAP_END) begin
                        cnt <= '0;
                        if (!frame) begin
                            frame    <= 1'b1;
                            sh       <= 8'h00;
                            spi_nss  <= 1'b0;
                            spi_mosi <= 1'b0;
                            state    <= LEAD;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_cmd_master.sv
// Directed bench for spi_cmd_master with a behavioural SPI command slave.
// Checks responses, frame contents, SPI timing, busy handshake and reset abort.
module tb_spi_cmd_master;
    logic clk = 1'b0;
    logic nrst;
    logic busy, spi_ck, spi_mosi, spi_nss;
    logic spi_miso = 1'b0;

    spi_cmd_master_if bus ();

    spi_cmd_master dut (
        .clk      (clk),
        .nrst     (nrst),
        .host     (bus),
        .busy     (busy),
        .spi_ck   (spi_ck),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_nss  (spi_nss)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Slave: samples MOSI on SCK rise, shifts MISO on SCK fall,
    // and computes its response when NSS rises after a full byte.
    logic [7:0] s_rx = 8'h00;
    logic [7:0] s_tx = 8'h00;
    logic [7:0] s_resp = 8'h00;
    logic [2:0] clk_sel = 3'd0;
    int         s_bits = 0;
    logic [7:0] frames[$];

    always @(negedge spi_nss) begin
        s_tx     <= s_resp;
        spi_miso <= s_resp[7];
        s_bits   <= 0;
    end

    always @(posedge spi_ck) begin
        if (!spi_nss) begin
            s_rx   <= {s_rx[6:0], spi_mosi};
            s_bits <= s_bits + 1;
        end
    end

    always @(negedge spi_ck) begin
        if (!spi_nss) begin
            spi_miso <= s_tx[6];
            s_tx     <= {s_tx[6:0], 1'b0};
        end
    end

    always @(posedge spi_nss) begin
        if (s_bits == 8) begin
            frames.push_back(s_rx);
            case (s_rx[7:5])
                3'b000: ;
                3'b001: s_resp <= 8'h81;
                3'b010: begin
                    clk_sel <= s_rx[2:0];
                    s_resp  <= 8'h80;
                end
                3'b011: s_resp <= {5'b10000, clk_sel};
                default: s_resp <= 8'h00;
            endcase
        end
    end

    // Timing monitor, sampled on the falling clk edge.
    logic stat_clr = 1'b0;
    logic p_ck = 1'b0, p_nss = 1'b1, p_mosi = 1'b0;
    int cyc = 0, t_nf = 0, t_nr = -1, t_r = 0, t_f = 0;
    int rises = 0, frame_rises = 0, lead_len = -1, gap_len = -1;
    int trail_len = -1, hi_min = 1000, hi_max = 0, lo_min = 1000;
    int lo_max = 0, mode_err = 0, rsp_pulses = 0, busy_cyc = 0;

    always @(negedge clk) begin
        cyc    <= cyc + 1;
        p_ck   <= spi_ck;
        p_nss  <= spi_nss;
        p_mosi <= spi_mosi;
        if (stat_clr) begin
            t_nr <= -1; gap_len <= -1; lead_len <= -1; trail_len <= -1;
            hi_min <= 1000; hi_max <= 0; lo_min <= 1000; lo_max <= 0;
            mode_err <= 0; rsp_pulses <= 0; busy_cyc <= 0;
            rises <= 0; frame_rises <= 0;
        end else begin
            if (bus.rsp_valid) rsp_pulses <= rsp_pulses + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (spi_ck && p_ck && spi_mosi !== p_mosi) mode_err <= mode_err + 1;
            if (!spi_nss && p_nss) begin
                t_nf  <= cyc;
                rises <= 0;
                if (t_nr >= 0) gap_len <= cyc - t_nr;
            end
            if (spi_nss && !p_nss) begin
                t_nr        <= cyc;
                frame_rises <= rises;
                trail_len   <= cyc - t_f;
            end
            if (spi_ck && !p_ck) begin
                t_r   <= cyc;
                rises <= rises + 1;
                if (rises == 0) lead_len <= cyc - t_nf;
                else begin
                    if (cyc - t_f < lo_min) lo_min <= cyc - t_f;
                    if (cyc - t_f > lo_max) lo_max <= cyc - t_f;
                end
            end
            if (!spi_ck && p_ck) begin
                t_f <= cyc;
                if (cyc - t_r < hi_min) hi_min <= cyc - t_r;
                if (cyc - t_r > hi_max) hi_max <= cyc - t_r;
            end
        end
    end

    int fbase = 0;

    task automatic clear_stats();
        fbase = frames.size();
        stat_clr = 1'b1;
        @(negedge clk);
        #1 stat_clr = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output logic [7:0] d,
                            output logic e);
        int n;
        n = 0;
        while (!bus.rsp_valid && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_rsp_timeout"}, n < 1000, 1);
        d = bus.rsp_data;
        e = bus.rsp_err;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle_timeout"}, n < 1000, 1);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] c,
                           output logic [7:0] d, output logic e);
        int n;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = c;
        n = 0;
        while (!bus.cmd_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_accept_timeout"}, n < 1000, 1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wait_rsp(tag, d, e);
        wait_idle(tag);
    endtask

    logic [7:0] d;
    logic       e;
    int         n;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nrst = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_nss", spi_nss, 1);
        check("rst_ck", spi_ck, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 8'h00);
        check("rst_rsp_err", bus.rsp_err, 0);
        check("rst_busy", busy, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("rst_ready", bus.cmd_ready, 1);

        // Status command
        clear_stats();
        run_cmd("t1", 8'h20, d, e);
        check("t1_nframes", frames.size() - fbase, 2);
        check("t1_frame0", frames[fbase], 8'h20);
        check("t1_frame1", frames[fbase+1], 8'h00);
        check("t1_rsp", d, 8'h81);
        check("t1_err", e, 0);
        check("t1_pulses", rsp_pulses, 1);
        repeat (10) @(negedge clk);
        check("t1_rsp_held", bus.rsp_data, 8'h81);

        // Set format then read it back
        run_cmd("t2a", 8'h45, d, e);
        check("t2_set_rsp", d, 8'h80);
        check("t2_set_err", e, 0);
        run_cmd("t2b", 8'h60, d, e);
        check("t2_get_rsp", d, 8'h85);
        check("t2_clk_sel", clk_sel, 3'd5);

        // Unknown instruction
        run_cmd("t3", 8'hE0, d, e);
        check("t3_rsp", d, 8'h00);
        check("t3_err", e, 1);
        check("t3_clk_sel", clk_sel, 3'd5);

        // Timing of a full exchange
        clear_stats();
        run_cmd("t4", 8'h20, d, e);
        check("t4_rsp", d, 8'h81);
        check("t4_busy_cycles", busy_cyc, 288);
        check("t4_hi_min", hi_min, 8);
        check("t4_hi_max", hi_max, 8);
        check("t4_lo_min", lo_min, 8);
        check("t4_lo_max", lo_max, 8);
        check("t4_lead", lead_len, 8);
        check("t4_trail", trail_len, 8);
        check("t4_gap", gap_len, 8);
        check("t4_rises", frame_rises, 8);
        check("t4_mode0", mode_err, 0);
        check("t4_pulses", rsp_pulses, 1);

        // cmd_valid held; data changes while busy are ignored
        clear_stats();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h20;
        @(negedge clk);
        check("t5_busy_after_accept", busy, 1);
        bus.cmd_data = 8'hE0;
        wait_rsp("t5a", d, e);
        check("t5_first_rsp", d, 8'h81);
        bus.cmd_data = 8'h60;
        wait_idle("t5a");
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        bus.cmd_valid = 1'b0;
        check("t5_idle_cycles", n, 1);
        @(negedge clk);
        wait_rsp("t5b", d, e);
        check("t5_second_rsp", d, 8'h85);
        wait_idle("t5b");
        check("t5_frame0", frames[fbase], 8'h20);
        check("t5_frame2", frames[fbase+2], 8'h60);

        // Reset in the middle of the command frame
        clear_stats();
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 8'h20;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        n = 0;
        while (rises < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("t6_reach_bit", n < 500, 1);
        repeat (3) @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("t6_nss", spi_nss, 1);
        check("t6_ck", spi_ck, 0);
        check("t6_busy", busy, 0);
        repeat (20) @(negedge clk);
        check("t6_no_rsp", rsp_pulses, 0);
        nrst = 1'b1;
        @(negedge clk);
        check("t6_ready", bus.cmd_ready, 1);
        run_cmd("t6", 8'h20, d, e);
        check("t6_rsp", d, 8'h81);
        check("t6_err", e, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
